bsg_tag_packet_serializer: RTL and testbench
============================================

# bsg_tag_packet_serializer

Synthesizable bsg_tag master-side serializer. It accepts one parallel tag packet at a time (client id, data/reset flag, length, payload) over a valid/ready handshake and emits it LSB-first as the single-bit `tag_data_o`/`tag_en_o` stream. It sits directly upstream of the clock-generator pearl's tag input, in place of the nonsynth trace-replay ROM path, so chip-level boot logic can program the oscillators, dividers and downsamplers.

## Interface
Parameters:
- `num_clients_p`, no default (BSG_INV_PARAM): number of tag clients; `id_w = BSG_SAFE_CLOG2(num_clients_p)`.
- `max_payload_width_p`, no default (BSG_INV_PARAM): largest payload; `len_w = BSG_SAFE_CLOG2(max_payload_width_p+1)`.
- `gap_cycles_p`, default 2: idle cycles forced between packets.

Ports:
- `clk_i` in 1: tag clock; the only clock.
- `reset_i` in 1: synchronous, active-high reset.
- `v_i` in 1: packet valid.
- `client_id_i` in id_w: destination client.
- `data_not_reset_i` in 1: 1 = data packet, 0 = client reset.
- `len_i` in len_w: number of payload bits to send.
- `payload_i` in max_payload_width_p: payload, bit 0 sent first.
- `ready_o` out 1: serializer can accept a packet.
- `tag_data_o` out 1: serial tag bit.
- `tag_en_o` out 1: tag bit valid.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- Packet wire order: start bit `1`, then `client_id_i` (id_w bits), then `data_not_reset_i`, then `len_i` (len_w bits), then `payload_i[len_i-1:0]`. Every field is sent LSB first.
- Packet bit count `N = 2 + id_w + len_w + len_i`.
- States:
  - PREAMBLE: only when the macro is enabled.
  - IDLE: `ready_o=1`.
  - SEND: shift out one bit per cycle.
  - GAP: count `gap_cycles_p` cycles.
- Handshake: accept on `v_i & ready_o` in IDLE. The packet is loaded into a shift register of width `2+id_w+len_w+max_payload_width_p` and a down-counter is loaded with N. `v_i` while not ready is ignored; the source holds it.
- SEND: drive the shift register's bit 0 and decrement the counter. When the counter reaches 0, go to GAP, or to IDLE if `gap_cycles_p=0`.
- `len_i=0`: send the header only (N = 2+id_w+len_w).
- `len_i > max_payload_width_p`: illegal. A nonsynth assertion fires. The bit count clamps to max_payload_width_p.
- Outside SEND: `tag_en_o=0` and `tag_data_o=0`.

## Timing
- Outputs are registered. `ready_o` and `busy_o` are decoded from the state register.
- Reset values: `tag_data_o=0`, `tag_en_o=0`, `busy_o=0`, `ready_o=1`. With the macro enabled: `busy_o=1` and `ready_o=0`.
- Acceptance at edge t: the first bit (start `1`) appears in cycle t+1 and the last bit in cycle t+N.
- GAP occupies cycles t+N+1 … t+N+gap_cycles_p. `ready_o` rises at cycle t+N+1+gap_cycles_p.
- Minimum accept-to-accept spacing: N+1+gap_cycles_p cycles.
- `reset_i` mid-packet: at the next edge, the state goes to IDLE (or PREAMBLE), `tag_en_o` drops to 0, and the partial packet is discarded without retry.

## Configuration
- `BSG_TAG_SERIALIZER_PREAMBLE_EN` defined: after reset, PREAMBLE holds `tag_en_o=1`, `tag_data_o=0` for `max_payload_width_p+id_w+len_w+2` cycles. This flushes downstream tag receivers. IDLE follows.
- Undefined: the PREAMBLE state is absent and reset goes straight to IDLE.

## Structure
- `bsg_tag_pkg` holds:
  - the `bsg_tag_packet_header_s` typedef `{len, data_not_reset, client_id}`;
  - width-helper localparams for id_w and len_w.
- The state enum stays local.
- One sub-module: `bsg_tag_packet_shifter` holds the shift register plus bit counter, with load/shift/last outputs. The top holds the FSM and handshake.

## Test plan
Common setup: `num_clients_p=4` (id_w=2), `max_payload_width_p=10` (len_w=4), `gap_cycles_p=2`.
- Basic data packet: id=2, dnr=1, len=3, payload=3'b101 -> 11 bits `1,0,1,1,1,1,0,0,1,0,1` with `tag_en_o=1` for exactly 11 cycles; `ready_o` rises 3 cycles after the last bit.
- Reset packet: id=3, dnr=0, len=0 -> 8 bits `1,1,1,0,0,0,0,0`; no payload bits.
- Back-to-back: `v_i` held high with two packets -> second start bit exactly N+3 cycles after the first start bit; `tag_en_o` low during the 2 gap cycles.
- Reset mid-packet: assert `reset_i` at bit 5 -> `tag_en_o=0` at the next edge; `ready_o=1` (macro off); the next packet is sent intact.
- Preamble (macro on): release reset -> 18 cycles of `tag_en_o=1`, `tag_data_o=0`, with `ready_o=0` throughout; `ready_o` rises the next cycle.
- End-to-end: the serializer drives the clk_gen pearl tag inputs with an oscillator-setting sequence -> the clock watcher reports the expected period change.

Source files
------------

// File: rtl/bsg_tag_pkg.sv
// ============================================================================
//  Module      : bsg_tag_pkg
//  Description : Shared definitions for the bsg_tag master-side serializer.
//                Holds the canonical packet header layout and the width
//                helpers used to size client-id and length fields.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bsg_tag_pkg;

    // Upper bounds for the header fields as carried in software-visible
    // structures; real packets use the narrower per-instance widths.
    localparam int c_TAG_MAX_ID_W  = 8;
    localparam int c_TAG_MAX_LEN_W = 8;

    // Header as it appears on the wire after the start bit (client_id first).
    typedef struct packed {
        logic [c_TAG_MAX_LEN_W-1:0] len;
        logic                       data_not_reset;
        logic [c_TAG_MAX_ID_W-1:0]  client_id;
    } bsg_tag_packet_header_s;

    // clog2 that never returns 0, so single-entry fields still get one bit.
    function automatic int bsg_tag_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Width of the client-id field for a given number of clients.
    function automatic int bsg_tag_id_width(input int num_clients);
        return bsg_tag_safe_clog2(num_clients);
    endfunction

    // Width of the length field; must be able to encode max_payload itself.
    function automatic int bsg_tag_len_width(input int max_payload);
        return bsg_tag_safe_clog2(max_payload + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_tag_packet_shifter.sv
// ============================================================================
//  Module      : bsg_tag_packet_shifter
//  Description : LSB-first shift register plus remaining-bit down-counter.
//                Bit 0 of the shift register is the bit currently on the tag
//                wire. When the final bit is shifted away the register is
//                cleared so the serial output idles at 0.
//  Ports       : clk_i     - tag clock
//                reset_i   - synchronous active-high reset
//                load_i    - capture packet_i / count_i
//                shift_i   - advance one bit
//                packet_i  - assembled packet, bit 0 first on the wire
//                count_i   - number of valid bits in packet_i
//                bit_o     - current serial bit (registered)
//                last_o    - the bit on bit_o is the final one
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_tag_packet_shifter #(
    parameter int width_p = 8,
    parameter int cnt_w_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [width_p-1:0] packet_i,
    input  logic [cnt_w_p-1:0] count_i,
    output logic               bit_o,
    output logic               last_o
);

    logic [width_p-1:0] r_sr;
    logic [cnt_w_p-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (load_i) begin
            r_sr  <= packet_i;
            r_cnt <= count_i;
        end else if (shift_i) begin
            if (last_o) begin
                // Drop unsent payload bits so the wire returns to 0.
                r_sr  <= '0;
                r_cnt <= '0;
            end else begin
                r_sr  <= {1'b0, r_sr[width_p-1:1]};
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bit_o  = r_sr[0];
    assign last_o = (r_cnt == cnt_w_p'(1));

endmodule

`default_nettype wire

// File: rtl/bsg_tag_packet_serializer.sv
// ============================================================================
//  Module      : bsg_tag_packet_serializer
//  Description : bsg_tag master-side serializer. Accepts one parallel tag
//                packet over valid/ready and emits it LSB-first as the
//                tag_data_o / tag_en_o serial stream:
//                  start(1), client_id, data_not_reset, len, payload[len-1:0]
//                A fixed number of idle cycles separates packets.
//  Config      : BSG_TAG_SERIALIZER_PREAMBLE_EN - when defined, after reset
//                the block drives tag_en_o=1 / tag_data_o=0 for
//                max_payload_width_p+id_w+len_w+2 cycles to flush the
//                downstream receivers before accepting packets.
//  Ports       : clk_i, reset_i (sync, active high)
//                v_i, client_id_i, data_not_reset_i, len_i, payload_i, ready_o
//                tag_data_o, tag_en_o (registered serial output)
//                busy_o (high whenever not idle)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_tag_packet_serializer
    import bsg_tag_pkg::*;
#(
    // Both width parameters are expected to be overridden per instance.
    parameter int num_clients_p       = 4,
    parameter int max_payload_width_p = 10,
    parameter int gap_cycles_p        = 2,
    localparam int c_ID_W  = bsg_tag_id_width(num_clients_p),
    localparam int c_LEN_W = bsg_tag_len_width(max_payload_width_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    input  logic [c_ID_W-1:0]              client_id_i,
    input  logic                           data_not_reset_i,
    input  logic [c_LEN_W-1:0]             len_i,
    input  logic [max_payload_width_p-1:0] payload_i,
    output logic                           ready_o,
    output logic                           tag_data_o,
    output logic                           tag_en_o,
    output logic                           busy_o
);

    localparam int c_PKT_W = 2 + c_ID_W + c_LEN_W + max_payload_width_p;
    localparam int c_CNT_W = bsg_tag_safe_clog2(c_PKT_W + 1);
    localparam int c_GAP_W = bsg_tag_safe_clog2(gap_cycles_p + 1);

    // Gap counter counts down to 0, so it is loaded with one less than the gap.
    localparam logic [c_GAP_W-1:0] c_GAP_INIT =
        c_GAP_W'((gap_cycles_p > 0) ? (gap_cycles_p - 1) : 0);
    localparam logic [c_LEN_W-1:0] c_LEN_MAX = c_LEN_W'(max_payload_width_p);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_GAP      = 2'd2,
        S_PREAMBLE = 2'd3
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic                 r_tag_en;
    logic                 w_tag_en_next;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [c_GAP_W-1:0]   w_gap_next;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_bit;
    logic                 w_last;
    logic [c_LEN_W-1:0]   w_len_eff;
    logic [c_PKT_W-1:0]   w_packet;
    logic [c_CNT_W-1:0]   w_count;

`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
    logic [c_CNT_W-1:0]   r_pre_cnt;
    logic [c_CNT_W-1:0]   w_pre_next;
`endif

    // Oversized lengths are clamped so the counter never runs past the
    // shift register.
    assign w_len_eff = (len_i > c_LEN_MAX) ? c_LEN_MAX : len_i;
    assign w_packet  = {payload_i, w_len_eff, data_not_reset_i, client_id_i, 1'b1};
    assign w_count   = c_CNT_W'(2 + c_ID_W + c_LEN_W) + c_CNT_W'(w_len_eff);

    bsg_tag_packet_shifter #(
        .width_p (c_PKT_W),
        .cnt_w_p (c_CNT_W)
    ) u_shifter (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (w_load),
        .shift_i  (w_shift),
        .packet_i (w_packet),
        .count_i  (w_count),
        .bit_o    (w_bit),
        .last_o   (w_last)
    );

    always_comb begin
        w_state_next  = r_state;
        w_tag_en_next = 1'b0;
        w_gap_next    = r_gap_cnt;
        w_load        = 1'b0;
        w_shift       = 1'b0;
`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
        w_pre_next    = r_pre_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (v_i) begin
                    w_load        = 1'b1;
                    w_tag_en_next = 1'b1;
                    w_state_next  = S_SEND;
                end
            end
            S_SEND: begin
                w_shift = 1'b1;
                if (w_last) begin
                    if (gap_cycles_p == 0) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_GAP;
                        w_gap_next   = c_GAP_INIT;
                    end
                end else begin
                    w_tag_en_next = 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_next = r_gap_cnt - 1'b1;
                end
            end
            S_PREAMBLE: begin
`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
                // tag_data_o stays 0 because the shift register is empty.
                if (r_pre_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_tag_en_next = 1'b1;
                    w_pre_next    = r_pre_cnt - 1'b1;
                end
`else
                w_state_next = S_IDLE;
`endif
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
            r_state   <= S_PREAMBLE;
            r_pre_cnt <= c_CNT_W'(c_PKT_W);
`else
            r_state   <= S_IDLE;
`endif
            r_tag_en  <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_tag_en  <= w_tag_en_next;
            r_gap_cnt <= w_gap_next;
`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
            r_pre_cnt <= w_pre_next;
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && v_i && ready_o) begin
            assert (len_i <= c_LEN_MAX)
                else $error("bsg_tag_packet_serializer: len_i=%0d exceeds max_payload_width_p=%0d",
                            len_i, max_payload_width_p);
        end
    end
`endif

    assign ready_o    = (r_state == S_IDLE);
    assign busy_o     = (r_state != S_IDLE);
    assign tag_en_o   = r_tag_en;
    assign tag_data_o = w_bit;

endmodule

`default_nettype wire

// File: tb/tb_bsg_tag_packet_serializer.sv
// ============================================================================
//  Module      : tb_bsg_tag_packet_serializer
//  Description : Directed self-checking bench for bsg_tag_packet_serializer
//                (4 clients, 10-bit max payload, 2 gap cycles).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bsg_tag_packet_serializer;

    localparam int NUM_CLIENTS = 4;
    localparam int MAX_PAYLOAD = 10;
    localparam int GAP         = 2;
    localparam int ID_W        = 2;
    localparam int LEN_W       = 4;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic                   v_i;
    logic [ID_W-1:0]        client_id_i;
    logic                   data_not_reset_i;
    logic [LEN_W-1:0]       len_i;
    logic [MAX_PAYLOAD-1:0] payload_i;
    logic                   ready_o;
    logic                   tag_data_o;
    logic                   tag_en_o;
    logic                   busy_o;

    int n_err = 0;
    int n_chk = 0;

    logic [63:0] en_m, dat_m, rdy_m, exp_bits;

    bsg_tag_packet_serializer #(
        .num_clients_p       (NUM_CLIENTS),
        .max_payload_width_p (MAX_PAYLOAD),
        .gap_cycles_p        (GAP)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .client_id_i      (client_id_i),
        .data_not_reset_i (data_not_reset_i),
        .len_i            (len_i),
        .payload_i        (payload_i),
        .ready_o          (ready_o),
        .tag_data_o       (tag_data_o),
        .tag_en_o         (tag_en_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Bounded wait for ready_o; an expired bound counts as a failed check.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_ready_wait"}, 64'(ready_o), 64'd1);
    endtask

    // Sends one packet and records the window from the first bit through
    // two cycles past the point where ready_o should return.
    task automatic run_packet(input string tag, input logic [ID_W-1:0] id, input logic dnr,
                              input logic [LEN_W-1:0] len, input logic [MAX_PAYLOAD-1:0] pl,
                              input int n_bits, input logic [63:0] bits);
        int win;
        wait_ready(tag);
        v_i = 1'b1; client_id_i = id; data_not_reset_i = dnr; len_i = len; payload_i = pl;
        tick();
        v_i = 1'b0;
        win = n_bits + GAP + 2;
        en_m = '0; dat_m = '0; rdy_m = '0;
        for (int c = 0; c < win; c++) begin
            en_m[c]  = tag_en_o;
            dat_m[c] = tag_data_o;
            rdy_m[c] = ready_o;
            tick();
        end
        check({tag, "_en"},    en_m,  (64'd1 << n_bits) - 64'd1);
        check({tag, "_data"},  dat_m, bits);
        check({tag, "_ready"}, rdy_m, 64'd3 << (n_bits + GAP));
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; client_id_i = '0; data_not_reset_i = 1'b0;
        len_i = '0; payload_i = '0;
        repeat (3) tick();

        // Reset state
        check("rst_tag_en",   64'(tag_en_o),   64'd0);
        check("rst_tag_data", 64'(tag_data_o), 64'd0);
`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
        check("rst_busy",  64'(busy_o),  64'd1);
        check("rst_ready", 64'(ready_o), 64'd0);
`else
        check("rst_busy",  64'(busy_o),  64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);
`endif
        reset_i = 1'b0;

`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
        // 18 flush cycles: en=1, data=0, not ready
        en_m = '0; dat_m = '0; rdy_m = '0;
        for (int c = 0; c < 18; c++) begin
            tick();
            en_m[c] = tag_en_o; dat_m[c] = tag_data_o; rdy_m[c] = ready_o;
        end
        check("pre_en",    en_m,  64'h3FFFF);
        check("pre_data",  dat_m, 64'd0);
        check("pre_ready", rdy_m, 64'd0);
        tick();
        check("pre_done_ready", 64'(ready_o),  64'd1);
        check("pre_done_en",    64'(tag_en_o), 64'd0);
`else
        tick();
        check("idle_ready", 64'(ready_o),  64'd1);
        check("idle_en",    64'(tag_en_o), 64'd0);
`endif

        // Basic data packet; payload bits above len must not be sent.
        exp_bits = 64'b10100111101;
        run_packet("basic", 2'd2, 1'b1, 4'd3, 10'h3FD, 11, exp_bits);

        // Client reset packet, header only
        exp_bits = 64'b00000111;
        run_packet("clrst", 2'd3, 1'b0, 4'd0, 10'h000, 8, exp_bits);

        // Full-length payload
        exp_bits = 64'b110011010110101011;
        run_packet("full", 2'd1, 1'b1, 4'd10, 10'b1100110101, 18, exp_bits);

        // Back-to-back with v_i held high: second start bit N+3 after the first
        wait_ready("b2b");
        v_i = 1'b1; client_id_i = 2'd2; data_not_reset_i = 1'b1; len_i = 4'd3; payload_i = 10'h005;
        tick();
        client_id_i = 2'd3; data_not_reset_i = 1'b0; len_i = 4'd0; payload_i = 10'h000;
        en_m = '0; dat_m = '0; rdy_m = '0;
        for (int c = 0; c < 26; c++) begin
            if (c == 14) v_i = 1'b0;
            en_m[c] = tag_en_o; dat_m[c] = tag_data_o; rdy_m[c] = ready_o;
            tick();
        end
        v_i = 1'b0;
        check("b2b_en",    en_m,  64'h7FF | (64'hFF << 14));
        check("b2b_data",  dat_m, 64'b10100111101 | (64'b00000111 << 14));
        check("b2b_ready", rdy_m, (64'd1 << 13) | (64'd3 << 24));

        // Reset asserted while bit 5 is on the wire
        wait_ready("midrst");
        v_i = 1'b1; client_id_i = 2'd2; data_not_reset_i = 1'b1; len_i = 4'd3; payload_i = 10'h005;
        tick();
        v_i = 1'b0;
        dat_m = '0; en_m = '0;
        for (int c = 0; c < 5; c++) begin
            dat_m[c] = tag_data_o; en_m[c] = tag_en_o;
            tick();
        end
        dat_m[5] = tag_data_o; en_m[5] = tag_en_o;
        check("midrst_pre_data", dat_m, 64'b111101);
        check("midrst_pre_en",   en_m,  64'h3F);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("midrst_en",   64'(tag_en_o),   64'd0);
        check("midrst_data", 64'(tag_data_o), 64'd0);
`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_busy",  64'(busy_o),  64'd1);
`else
        check("midrst_ready", 64'(ready_o), 64'd1);
        check("midrst_busy",  64'(busy_o),  64'd0);
        tick();
        check("midrst_no_retry", 64'(tag_en_o), 64'd0);
`endif

        // Next packet after the aborted one goes out intact
        exp_bits = 64'b110011010110101011;
        run_packet("after_rst", 2'd1, 1'b1, 4'd10, 10'b1100110101, 18, exp_bits);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
